// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer write master.
`timescale 1ns/1ps
package fb_pkg;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    IDLE = 2'd1,
    BUSY = 2'd2
  } state_t;

  localparam int BYTES_PER_PIX = 4;

  localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
  localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;
  localparam logic [3:0] WB_SEL_ALL     = 4'hF;

  function automatic int idx_width(input int pixels);
    return (pixels > 1) ? $clog2(pixels) : 1;
  endfunction

endpackage

// File: rtl/fb_writer_addr_gen.sv
// Pixel index / byte offset counters and base latch; produces the registered
// address of the most recently accepted pixel.
`timescale 1ns/1ps
module fb_addr_gen
  import fb_pkg::*;
#(
  parameter int HDISP = 800,
  parameter int VDISP = 480,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step,
  input  logic          sof,
  input  logic          restart,
  input  logic [AW-1:0] fb_base,
  output logic [AW-1:0] adr,
  output logic          last,
  output logic          sof_err
);

  localparam int NPIX = HDISP * VDISP;
  localparam int IW   = idx_width(NPIX);
  localparam int OW   = IW + 2;

  logic [IW-1:0] index_reg, index_cur, index_next;
  logic [OW-1:0] offset_reg, offset_cur, offset_next;
  logic [AW-1:0] base_reg, base_cur;
  logic [AW-1:0] adr_reg;
  logic          last_reg, sof_err_reg, wrap;

  // An SOF pixel always lands at offset 0 of the freshly sampled base.
  always_comb begin
    index_cur   = sof ? '0 : index_reg;
    offset_cur  = sof ? '0 : offset_reg;
    base_cur    = sof ? fb_base : base_reg;
    wrap        = (index_cur == IW'(NPIX - 1));
    index_next  = wrap ? '0 : index_cur + IW'(1);
    offset_next = wrap ? '0 : offset_cur + OW'(BYTES_PER_PIX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_reg   <= '0;
      offset_reg  <= '0;
      base_reg    <= '0;
      adr_reg     <= '0;
      last_reg    <= 1'b0;
      sof_err_reg <= 1'b0;
    end else begin
      sof_err_reg <= step && sof && !restart && (index_reg != '0);
      if (step) begin
        index_reg  <= index_next;
        offset_reg <= offset_next;
        base_reg   <= base_cur;
        adr_reg    <= base_cur + AW'(offset_cur);
        last_reg   <= wrap;
      end
    end
  end

  assign adr     = adr_reg;
  assign last    = last_reg;
  assign sof_err = sof_err_reg;

endmodule

// File: rtl/fb_writer.sv
// Wishbone classic-cycle write master streaming raster-order pixels into the
// framebuffer, one 32-bit word per pixel.
`timescale 1ns/1ps
module fb_writer
  import fb_pkg::*;
#(
  parameter int HDISP = 800,
  parameter int VDISP = 480,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [AW-1:0] fb_base,
  input  logic          pix_valid,
  output logic          pix_ready,
  input  logic [31:0]   pix_data,
  input  logic          pix_sof,
  output logic [AW-1:0] wb_adr,
  output logic [31:0]   wb_dat_ms,
  output logic          wb_we,
  output logic          wb_cyc,
  output logic          wb_stb,
  output logic [3:0]    wb_sel,
  output logic [2:0]    wb_cti,
  output logic [1:0]    wb_bte,
  input  logic          wb_ack,
  output logic          frame_done,
  output logic          sof_err
);

  state_t      state_reg;
  logic        stb_reg, frame_done_reg;
  logic [31:0] dat_reg;
  logic        accept, step, last;

  // Ready follows the current ack so a zero-wait slave sustains one pixel per cycle.
  always_comb begin
    pix_ready = 1'b0;
    if (rst_n) begin
      case (state_reg)
        SYNC:    pix_ready = enable;
        IDLE:    pix_ready = 1'b1;
        BUSY:    pix_ready = wb_ack && enable;
        default: pix_ready = 1'b0;
      endcase
    end
  end

  assign accept = pix_valid && pix_ready;
  assign step   = accept && ((state_reg != SYNC) || pix_sof);

  fb_addr_gen #(
    .HDISP (HDISP),
    .VDISP (VDISP),
    .AW    (AW)
  ) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .step    (step),
    .sof     (pix_sof),
    .restart (state_reg == SYNC),
    .fb_base (fb_base),
    .adr     (wb_adr),
    .last    (last),
    .sof_err (sof_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= SYNC;
      stb_reg        <= 1'b0;
      dat_reg        <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= (state_reg == BUSY) && wb_ack && last;
      case (state_reg)
        SYNC: begin
          if (accept && pix_sof) begin
            state_reg <= BUSY;
            stb_reg   <= 1'b1;
            dat_reg   <= pix_data;
          end
        end
        IDLE: begin
          if (accept) begin
            state_reg <= BUSY;
            stb_reg   <= 1'b1;
            dat_reg   <= pix_data;
          end else if (!enable) begin
            state_reg <= SYNC;
          end
        end
        BUSY: begin
          if (wb_ack) begin
            if (accept) begin
              dat_reg <= pix_data;
            end else begin
              stb_reg   <= 1'b0;
              state_reg <= enable ? IDLE : SYNC;
            end
          end
        end
        default: begin
          state_reg <= SYNC;
          stb_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign wb_stb     = stb_reg;
  assign wb_cyc     = stb_reg;
  assign wb_we      = stb_reg;
  assign wb_dat_ms  = dat_reg;
  assign wb_sel     = WB_SEL_ALL;
  assign wb_cti     = WB_CTI_CLASSIC;
  assign wb_bte     = WB_BTE_LINEAR;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_fb_writer.sv
// Bench for fb_writer: directed phases plus a random phase, all checked
// against a raster-order reference model with a programmable-wait slave.
`timescale 1ns/1ps
module tb_fb_writer;

  localparam int HDISP = 4;
  localparam int VDISP = 2;
  localparam int AW    = 32;
  localparam int NPIX  = HDISP * VDISP;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [AW-1:0] fb_base = '0;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic [31:0]   pix_data = '0;
  logic          pix_sof = 1'b0;
  logic [AW-1:0] wb_adr;
  logic [31:0]   wb_dat_ms;
  logic          wb_we, wb_cyc, wb_stb;
  logic [3:0]    wb_sel;
  logic [2:0]    wb_cti;
  logic [1:0]    wb_bte;
  logic          wb_ack;
  logic          frame_done, sof_err;

  fb_writer #(.HDISP(HDISP), .VDISP(VDISP), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .fb_base    (fb_base),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .pix_sof    (pix_sof),
    .wb_adr     (wb_adr),
    .wb_dat_ms  (wb_dat_ms),
    .wb_we      (wb_we),
    .wb_cyc     (wb_cyc),
    .wb_stb     (wb_stb),
    .wb_sel     (wb_sel),
    .wb_cti     (wb_cti),
    .wb_bte     (wb_bte),
    .wb_ack     (wb_ack),
    .frame_done (frame_done),
    .sof_err    (sof_err)
  );

  always #5 clk = ~clk;

  // Slave: acks once the strobe has been waiting wait_states cycles.
  int wait_states = 0;
  int wcnt = 0;
  always @(posedge clk) begin
    if (!rst_n || !wb_stb || wb_ack) wcnt <= 0;
    else                             wcnt <= wcnt + 1;
  end
  assign wb_ack = wb_stb && (wcnt >= wait_states);

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    bit          last;
  } wr_t;

  wr_t         exp_q[$];
  bit          synced = 1'b0;
  int          idx = 0;
  logic [31:0] base = '0;
  bit          exp_fd = 1'b0;
  bit          exp_se = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: update the model from the values present at the coming edge,
  // then check the registered outputs just after it.
  task automatic tick(output bit acc);
    bit  ack;
    wr_t w;
    @(negedge clk);
    acc    = pix_valid && pix_ready;
    ack    = wb_stb && wb_ack;
    exp_fd = 1'b0;
    exp_se = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      synced = 1'b0;
      idx    = 0;
      base   = '0;
    end else begin
      if (wb_stb && !wb_ack) check("ready_in_wait", {31'd0, pix_ready}, 32'd0);
      if (exp_q.size() == 0) check("ready_idle", {31'd0, pix_ready}, {31'd0, synced ? 1'b1 : enable});
      if (ack && exp_q.size() != 0) begin
        w      = exp_q.pop_front();
        exp_fd = w.last;
      end
      if (acc && (synced || pix_sof)) begin
        if (!synced) begin
          synced = 1'b1;
          idx    = 0;
          base   = fb_base;
        end else if (pix_sof) begin
          if (idx != 0) exp_se = 1'b1;
          idx  = 0;
          base = fb_base;
        end
        w.adr  = base + 32'(4 * idx);
        w.dat  = pix_data;
        w.last = (idx == NPIX - 1);
        exp_q.push_back(w);
        idx = (idx + 1) % NPIX;
      end
      if (!enable && !acc && exp_q.size() == 0) synced = 1'b0;
    end
    @(posedge clk);
    #1;
    if (rst_n) begin
      check("stb", {31'd0, wb_stb}, {31'd0, exp_q.size() != 0});
      check("cyc", {31'd0, wb_cyc}, {31'd0, exp_q.size() != 0});
      check("we", {31'd0, wb_we}, {31'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        check("adr", wb_adr, exp_q[0].adr);
        check("dat", wb_dat_ms, exp_q[0].dat);
      end
      check("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
      check("sof_err", {31'd0, sof_err}, {31'd0, exp_se});
    end
  endtask

  task automatic send(input logic [31:0] data, input bit sof);
    bit acc;
    int t;
    pix_valid = 1'b1;
    pix_data  = data;
    pix_sof   = sof;
    acc = 1'b0;
    t   = 0;
    while (!acc && t < 60) begin
      tick(acc);
      t++;
    end
    check("accept_timeout", {31'd0, acc}, 32'd1);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int t;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    t = 0;
    tick(acc);
    while ((exp_q.size() != 0 || wb_stb) && t < 60) begin
      tick(acc);
      t++;
    end
    check("drain_timeout", {31'd0, wb_stb}, 32'd0);
  endtask

  initial begin
    bit acc;
    enable = 1'b1;
    #12;
    check("rst_stb", {31'd0, wb_stb}, 32'd0);
    check("rst_cyc", {31'd0, wb_cyc}, 32'd0);
    check("rst_we", {31'd0, wb_we}, 32'd0);
    check("rst_ready", {31'd0, pix_ready}, 32'd0);
    check("rst_adr", wb_adr, 32'd0);
    check("rst_dat", wb_dat_ms, 32'd0);
    check("rst_fd", {31'd0, frame_done}, 32'd0);
    check("rst_se", {31'd0, sof_err}, 32'd0);
    check("sel", {28'd0, wb_sel}, 32'hF);
    check("cti", {29'd0, wb_cti}, 32'd0);
    check("bte", {30'd0, wb_bte}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Non-SOF pixels dropped, then a full zero-wait frame.
    fb_base = 32'h1000;
    wait_states = 0;
    for (int i = 0; i < 3; i++) send($urandom, 1'b0);
    send($urandom, 1'b1);
    for (int i = 1; i < NPIX; i++) send($urandom, 1'b0);
    drain();

    // Three wait states per access.
    wait_states = 3;
    for (int i = 0; i < 5; i++) send($urandom, 1'b0);
    drain();

    // Early SOF with a new base.
    wait_states = 1;
    send($urandom, 1'b1);
    send($urandom, 1'b0);
    fb_base = 32'h2000;
    send($urandom, 1'b1);
    for (int i = 0; i < 3; i++) send($urandom, 1'b0);
    drain();

    // Disable while a write is outstanding, then re-enable.
    wait_states = 3;
    send($urandom, 1'b0);
    enable = 1'b0;
    drain();
    tick(acc);
    check("parked_ready", {31'd0, pix_ready}, 32'd0);
    enable = 1'b1;
    send($urandom, 1'b0);
    send($urandom, 1'b0);
    send($urandom, 1'b1);
    send($urandom, 1'b0);
    drain();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      enable      = ($urandom % 16) != 0;
      wait_states = $urandom % 3;
      pix_valid   = ($urandom % 4) != 0;
      pix_sof     = ($urandom % 12) == 0;
      pix_data    = $urandom;
      if ($urandom % 8 == 0) fb_base = (($urandom % 8) == 0) ? 32'hFFFF_FFF0 : 32'h1000 * (($urandom % 4) + 1);
      tick(acc);
    end
    enable = 1'b1;
    drain();

    // Asynchronous reset in the middle of a write.
    wait_states = 3;
    fb_base = 32'h3000;
    send($urandom, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_stb", {31'd0, wb_stb}, 32'd0);
    check("arst_cyc", {31'd0, wb_cyc}, 32'd0);
    check("arst_we", {31'd0, wb_we}, 32'd0);
    check("arst_adr", wb_adr, 32'd0);
    tick(acc);
    rst_n = 1'b1;
    wait_states = 0;
    send($urandom, 1'b0);
    send($urandom, 1'b1);
    send($urandom, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
